// File: rtl/load_compute_sched.sv
// -----------------------------------------------------------------------------
// load_compute_sched
//
// Session controller for the load/compute datapath. While `load` is high it
// counts streamed input words into the operand buffer. It then sequences the
// compute phase: for each of NUM_OUT results it issues TAPS buffer reads with
// accumulator controls, and presents the result through a valid/ready
// handshake.
//
// Optional feature macro: LOAD_OVF_CHK_EN
//   When defined, the block has an extra output `ovf`. This sticky flag is set
//   when a word arrives while the buffer is already full. It is cleared by the
//   next start or by arst.
//
// Parameters
//   DEPTH    operand buffer depth in words (>= 2)
//   TAPS     reads accumulated per result (1..DEPTH)
//   NUM_OUT  results produced per session (1..DEPTH)
//   AW       buffer address width, $clog2(DEPTH)
//
// Ports
//   clk        rising-edge clock
//   arst       asynchronous reset, active-high
//   start      begin a session (honoured in IDLE only)
//   load       input word valid this cycle
//   wr_en      buffer write strobe (LOAD only)
//   wr_addr    buffer write address
//   rd_en      buffer read strobe (CALC only)
//   rd_addr    buffer read address, (result + tap) mod word_cnt
//   acc_clr    accumulator clear, asserted with the first read of a result
//   acc_en     accumulator enable
//   out_valid  result available (registered)
//   out_ready  consumer accepts result
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of a session
//   word_cnt   words loaded this session (0..DEPTH)
//   ovf        sticky overflow flag (LOAD_OVF_CHK_EN only)
// -----------------------------------------------------------------------------
module load_compute_sched #(
    parameter int DEPTH   = 16,
    parameter int TAPS    = 4,
    parameter int NUM_OUT = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          start,
    input  logic          load,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   word_cnt
`ifdef LOAD_OVF_CHK_EN
    ,
    output logic          ovf
`endif
);

    // Counter widths. A width of at least 1 keeps TAPS=1 / NUM_OUT=1 legal.
    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
    localparam logic [OW-1:0] RES_LAST   = OW'(NUM_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q,     state_d;
    logic [AW:0]   word_cnt_q,  word_cnt_d;
    logic [AW-1:0] base_q,      base_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [TW-1:0] tap_q,       tap_d;
    logic [OW-1:0] res_q,       res_d;
    logic          out_valid_q, out_valid_d;
`ifdef LOAD_OVF_CHK_EN
    logic          ovf_q,       ovf_d;
`endif

    logic          buf_full_s;
    logic [AW-1:0] base_inc_s;

    // Pointer increment that wraps to 0 at `limit`. This gives the mod
    // word_cnt address sequence without a divider. The >= compare also covers
    // a pointer that is already past a shorter limit.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr,
                                              input logic [AW:0]   limit);
        logic [AW:0] nxt;
        nxt = {1'b0, ptr} + {{AW{1'b0}}, 1'b1};
        if (nxt >= limit) begin
            return {AW{1'b0}};
        end else begin
            return nxt[AW-1:0];
        end
    endfunction

    assign buf_full_s = (word_cnt_q >= DEPTH_W);
    assign base_inc_s = ptr_inc(base_q, word_cnt_q);

    // Next-state and counter update logic.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        base_d      = base_q;
        rd_ptr_d    = rd_ptr_q;
        tap_d       = tap_q;
        res_d       = res_q;
        out_valid_d = 1'b0;
`ifdef LOAD_OVF_CHK_EN
        ovf_d       = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    word_cnt_d = {(AW+1){1'b0}};
`ifdef LOAD_OVF_CHK_EN
                    ovf_d      = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_LOAD: begin
                if (load) begin
                    // Words beyond DEPTH are dropped. The count saturates.
                    if (!buf_full_s) begin
                        word_cnt_d = word_cnt_q + {{AW{1'b0}}, 1'b1};
                    end else begin
                        word_cnt_d = word_cnt_q;
`ifdef LOAD_OVF_CHK_EN
                        ovf_d      = 1'b1;
`endif
                    end
                end else if (word_cnt_q != {(AW+1){1'b0}}) begin
                    state_d  = S_CALC;
                    base_d   = {AW{1'b0}};
                    rd_ptr_d = {AW{1'b0}};
                    tap_d    = {TW{1'b0}};
                    res_d    = {OW{1'b0}};
                end else begin
                    // Nothing has been loaded yet. Keep waiting for words.
                    state_d = S_LOAD;
                end
            end

            S_CALC: begin
                rd_ptr_d = ptr_inc(rd_ptr_q, word_cnt_q);
                if (tap_q == TAP_LAST) begin
                    state_d     = S_OUT;
                    tap_d       = {TW{1'b0}};
                    out_valid_d = 1'b1;
                end else begin
                    tap_d = tap_q + {{(TW-1){1'b0}}, 1'b1};
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (res_q == RES_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        // The next result's reads start one word further on.
                        state_d  = S_CALC;
                        res_d    = res_q + {{(OW-1){1'b0}}, 1'b1};
                        base_d   = base_inc_s;
                        rd_ptr_d = base_inc_s;
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers. arst aborts any session immediately.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= {(AW+1){1'b0}};
            base_q      <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            tap_q       <= {TW{1'b0}};
            res_q       <= {OW{1'b0}};
            out_valid_q <= 1'b0;
`ifdef LOAD_OVF_CHK_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            base_q      <= base_d;
            rd_ptr_q    <= rd_ptr_d;
            tap_q       <= tap_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
`ifdef LOAD_OVF_CHK_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    // Output decode. Every output is a direct function of registered state.
    // wr_en is the exception: it also follows `load` in the same cycle.
    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = {AW{1'b0}};
        rd_en    = 1'b0;
        rd_addr  = {AW{1'b0}};
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        case (state_q)
            S_LOAD: begin
                wr_en   = load & ~buf_full_s;
                wr_addr = word_cnt_q[AW-1:0];
            end
            S_CALC: begin
                rd_en   = 1'b1;
                rd_addr = rd_ptr_q;
                acc_clr = (tap_q == {TW{1'b0}});
                acc_en  = 1'b1;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign word_cnt  = word_cnt_q;
`ifdef LOAD_OVF_CHK_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_load_compute_sched.sv
// -----------------------------------------------------------------------------
// tb_load_compute_sched
//
// Table-driven bench for load_compute_sched (DEPTH=16, TAPS=4, NUM_OUT=8).
// Each table row describes one session: the load length, an optional gap of
// idle LOAD cycles, an optional out_ready stall and an optional start/load
// glitch. Each row also carries hand-computed expectations. A short
// hand-written sequence covers an asynchronous reset in the middle of CALC.
// -----------------------------------------------------------------------------
module tb_load_compute_sched;

    localparam int DEPTH   = 16;
    localparam int TAPS    = 4;
    localparam int NUM_OUT = 8;

    logic       clk = 1'b0;
    logic       arst, start, load, out_ready;
    logic       wr_en, rd_en, acc_clr, acc_en, out_valid, busy, done;
    logic [3:0] wr_addr, rd_addr;
    logic [4:0] word_cnt;
`ifdef LOAD_OVF_CHK_EN
    logic       ovf;
`endif

    always #5 clk = ~clk;

    load_compute_sched #(.DEPTH(DEPTH), .TAPS(TAPS), .NUM_OUT(NUM_OUT)) dut (
        .clk       (clk),
        .arst      (arst),
        .start     (start),
        .load      (load),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .word_cnt  (word_cnt)
`ifdef LOAD_OVF_CHK_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        int                    n_load;
        int                    gap;
        int                    stall_o;
        int                    stall_n;
        logic                  glitch;
        int                    exp_wc;
        int                    chk_o;
        logic [TAPS-1:0][3:0]  exp_a;
        int                    exp_done;
        logic                  exp_ovf;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Session observations.
    int rd_log [NUM_OUT][TAPS];
    int n_hand, done_cyc, wr_cnt, drop_cnt, bad_wr_addr, bad_clr;
    int stall_rd, stalled, extra_rd, bad_cnt, bad_wr_calc, gap_bad;
    int seen_done;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n_load, input int gap, input int stall_o,
                                input int stall_n, input logic glitch, input int exp_wc,
                                input int chk_o, input int a0, input int a1,
                                input int a2, input int a3, input int exp_done,
                                input logic exp_ovf);
        vec_t v;
        v.n_load   = n_load;
        v.gap      = gap;
        v.stall_o  = stall_o;
        v.stall_n  = stall_n;
        v.glitch   = glitch;
        v.exp_wc   = exp_wc;
        v.chk_o    = chk_o;
        v.exp_a[0] = 4'(a0);
        v.exp_a[1] = 4'(a1);
        v.exp_a[2] = 4'(a2);
        v.exp_a[3] = 4'(a3);
        v.exp_done = exp_done;
        v.exp_ovf  = exp_ovf;
        return v;
    endfunction

    // Drives one full session and records what the DUT did, cycle by cycle.
    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic run_session(input vec_t v);
        int  cyc;
        int  o;
        int  k;
        bit  glitch_arm;
        bit  pulse_now;
        cyc = 0; o = 0; k = 0; glitch_arm = 1'b0;
        n_hand = 0; done_cyc = -1; wr_cnt = 0; drop_cnt = 0; bad_wr_addr = 0;
        bad_clr = 0; stall_rd = 0; stalled = 0; extra_rd = 0; bad_cnt = 0;
        bad_wr_calc = 0; gap_bad = 0; seen_done = 0;
        for (int i = 0; i < NUM_OUT; i++)
            for (int j = 0; j < TAPS; j++) rd_log[i][j] = -1;

        // Start cycle: the DUT is still in IDLE while start is sampled.
        @(negedge clk);
        start = 1'b1; load = 1'b0; out_ready = 1'b1;
        #1; cyc++;
        chk("busy_before_start", busy, 0);

        // Idle LOAD cycles with load=0 must not leave LOAD or write.
        for (int g = 0; g < v.gap; g++) begin
            @(negedge clk);
            start = 1'b0; load = 1'b0;
            #1; cyc++;
            if (!busy || wr_en || rd_en || word_cnt != 5'd0) gap_bad++;
        end

        for (int i = 0; i < v.n_load; i++) begin
            @(negedge clk);
            start = v.glitch && (i == 1);
            load  = 1'b1;
            #1; cyc++;
            if (wr_en) begin
                wr_cnt++;
                if (int'(wr_addr) != i) bad_wr_addr++;
            end else begin
                drop_cnt++;
            end
        end

        for (int t = 0; t < 400 && seen_done == 0; t++) begin
            @(negedge clk);
            start = 1'b0; load = 1'b0; pulse_now = 1'b0;
            if (glitch_arm) begin
                start = 1'b1; load = 1'b1; glitch_arm = 1'b0; pulse_now = 1'b1;
            end
            out_ready = !(o == v.stall_o && stalled < v.stall_n);
            #1; cyc++;
            if (pulse_now && wr_en) bad_wr_calc++;
            if (rd_en) begin
                if (o < NUM_OUT && k < TAPS) rd_log[o][k] = int'(rd_addr);
                else extra_rd++;
                if (acc_clr != (k == 0) || !acc_en) bad_clr++;
                k++;
                if (v.glitch && o == 2 && k == 1) glitch_arm = 1'b1;
            end else if (acc_en || acc_clr) begin
                bad_clr++;
            end
            if (out_valid && !out_ready) begin
                stalled++;
                if (rd_en) stall_rd++;
            end
            if (out_valid && out_ready) begin
                if (k != TAPS) bad_cnt++;
                n_hand++; o++; k = 0;
            end
            if (done) begin
                done_cyc  = cyc;
                seen_done = 1;
            end
        end
        chk("done_seen", seen_done, 1);

        // The cycle after done: back in IDLE, done gone, word_cnt held.
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("word_cnt_hold", word_cnt, v.exp_wc);
    endtask

    vec_t vecs [8];

    initial begin
        int err;
        vecs[0] = mk(16, 0, -1, 0, 1'b0, 16, 0, 0, 1, 2, 3, 59, 1'b0);
        vecs[1] = mk(16, 0, -1, 0, 1'b0, 16, 7, 7, 8, 9, 10, 59, 1'b0);
        vecs[2] = mk(5,  0, -1, 0, 1'b0, 5,  3, 3, 4, 0, 1, 48, 1'b0);
        vecs[3] = mk(20, 0, -1, 0, 1'b0, 16, 7, 7, 8, 9, 10, 63, 1'b1);
        vecs[4] = mk(16, 0, 0,  7, 1'b0, 16, 1, 1, 2, 3, 4, 66, 1'b0);
        vecs[5] = mk(4,  3, -1, 0, 1'b1, 4,  2, 2, 3, 0, 1, 50, 1'b0);
        vecs[6] = mk(1,  0, -1, 0, 1'b0, 1,  5, 0, 0, 0, 0, 44, 1'b0);
        vecs[7] = mk(3,  0, -1, 0, 1'b0, 3,  6, 0, 1, 2, 0, 46, 1'b0);

        arst = 1'b1; start = 1'b0; load = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset_ctrl", int'({busy, done, rd_en, acc_en, acc_clr, out_valid, wr_en}), 0);
        chk("reset_word_cnt", word_cnt, 0);
        repeat (2) @(negedge clk);
        arst = 1'b0;

        for (int vi = 0; vi < 8; vi++) begin
            run_session(vecs[vi]);
            chk($sformatf("v%0d_wr_cnt", vi), wr_cnt, vecs[vi].exp_wc);
            chk($sformatf("v%0d_dropped", vi), drop_cnt, vecs[vi].n_load - vecs[vi].exp_wc);
            chk($sformatf("v%0d_wr_addr", vi), bad_wr_addr, 0);
            chk($sformatf("v%0d_gap", vi), gap_bad, 0);
            chk($sformatf("v%0d_handshakes", vi), n_hand, NUM_OUT);
            chk($sformatf("v%0d_done_cycle", vi), done_cyc, vecs[vi].exp_done);
            chk($sformatf("v%0d_acc_ctrl", vi), bad_clr, 0);
            chk($sformatf("v%0d_reads_per_result", vi), bad_cnt, 0);
            chk($sformatf("v%0d_extra_reads", vi), extra_rd, 0);
            chk($sformatf("v%0d_stall_cycles", vi), stalled, vecs[vi].stall_n);
            chk($sformatf("v%0d_reads_in_stall", vi), stall_rd, 0);
            chk($sformatf("v%0d_wr_in_calc", vi), bad_wr_calc, 0);
            for (int k = 0; k < TAPS; k++)
                chk($sformatf("v%0d_r%0d_addr%0d", vi, vecs[vi].chk_o, k),
                    rd_log[vecs[vi].chk_o][k], int'(vecs[vi].exp_a[k]));
            err = 0;
            for (int o = 0; o < NUM_OUT; o++)
                for (int k = 0; k < TAPS; k++)
                    if (rd_log[o][k] != (o + k) % vecs[vi].exp_wc) err++;
            chk($sformatf("v%0d_read_pattern", vi), err, 0);
`ifdef LOAD_OVF_CHK_EN
            chk($sformatf("v%0d_ovf", vi), ovf, int'(vecs[vi].exp_ovf));
`endif
        end

        // Asynchronous reset in the middle of CALC, then a clean session.
        @(negedge clk);
        start = 1'b1; load = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0; load = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        err = 1;
        for (int t = 0; t < 20 && err != 0; t++) begin
            @(negedge clk);
            #1;
            if (rd_en && !acc_clr) err = 0;
        end
        chk("reached_calc", err, 0);
        arst = 1'b1;
        #1;
        chk("arst_ctrl", int'({busy, done, rd_en, acc_en, acc_clr, out_valid, wr_en}), 0);
        chk("arst_word_cnt", word_cnt, 0);
        chk("arst_rd_addr", rd_addr, 0);
        @(negedge clk);
        arst = 1'b0;
        run_session(vecs[2]);
        chk("post_arst_done_cycle", done_cyc, vecs[2].exp_done);
        err = 0;
        for (int o = 0; o < NUM_OUT; o++)
            for (int k = 0; k < TAPS; k++)
                if (rd_log[o][k] != (o + k) % 5) err++;
        chk("post_arst_reads", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
